pipeline_hazard_unit: RTL and testbench

Parametrised hazard, forwarding and pipeline-advance controller for the five-stage MIPS core (IF, ID, EX, MEM, WB). It keeps registered shadow copies of the destination register, write-enable and load flag of the instructions in EX, MEM and WB. From these it produces stall, flush and forwarding selects for the ID operands. It also supports a multi-cycle data memory (MEM_LATENCY), global run/halt, and debug single-step.

---
 rtl/pipeline_hazard_unit.sv | 110 +++++++++++
 tb/tb_pipeline_hazard_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall, flush, forwarding and pipe-advance control for the five-stage core.
// Keeps shadow EX/MEM/WB destination slots and holds the pipe while a multi-cycle MEM access completes.
module pipeline_hazard_unit #(
   parameter int NB_ADDR     = 5,
   parameter int MEM_LATENCY = 1,
   parameter int NB_FWD_SEL  = 2
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_step_mode,
   input  logic                  i_step,
   input  logic [NB_ADDR-1:0]    i_id_rs_addr,
   input  logic [NB_ADDR-1:0]    i_id_rt_addr,
   input  logic                  i_id_rs_used,
   input  logic                  i_id_rt_used,
   input  logic [NB_ADDR-1:0]    i_id_dst_addr,
   input  logic                  i_id_rf_wr_enb,
   input  logic                  i_id_is_load,
   input  logic                  i_id_mem_access,
   input  logic                  i_ex_branch_taken,
   output logic                  o_pc_enable,
   output logic                  o_if_id_enable,
   output logic                  o_id_ex_enable,
   output logic                  o_ex_mem_enable,
   output logic                  o_flush_if_id,
   output logic                  o_flush_id_ex,
   output logic [NB_FWD_SEL-1:0] o_fwd_rs_sel,
   output logic [NB_FWD_SEL-1:0] o_fwd_rt_sel,
   output logic                  o_busy
);
   localparam int NB_CNT = 4;
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
   typedef struct packed {
      logic               valid;
      logic [NB_ADDR-1:0] dst;
      logic               wr_enb;
      logic               is_load;
      logic               mem_access;
   } slot_t;
   state_t            state_q, state_d, eff_state;
   logic [NB_CNT-1:0] cnt_q, cnt_d;
   slot_t             ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
   logic              adv, run_adv, load_use, front_adv, flush_ex, enter_wait;

   function automatic logic hit(slot_t s, logic [NB_ADDR-1:0] a, logic used);
      return used & s.valid & s.wr_enb & (s.dst != '0) & (s.dst == a);
   endfunction

   // A load still in EX has no result yet, so it falls through to older slots.
   function automatic logic [NB_FWD_SEL-1:0] fwd(slot_t ex, slot_t mem, slot_t wb, logic [NB_ADDR-1:0] a, logic used);
      return (hit(ex, a, used) & ~ex.is_load) ? NB_FWD_SEL'(1) :
             hit(mem, a, used) ? NB_FWD_SEL'(2) :
             hit(wb, a, used)  ? NB_FWD_SEL'(3) : '0;
   endfunction

   always_comb begin
      adv             = i_enable & (~i_step_mode | i_step);
      eff_state       = (state_q == HALT) ? ((cnt_q != '0) ? MEM_WAIT : RUN) : state_q;
      run_adv         = adv & ~i_reset & (eff_state == RUN);
      load_use        = ex_q.is_load & (hit(ex_q, i_id_rs_addr, i_id_rs_used) | hit(ex_q, i_id_rt_addr, i_id_rt_used));
      front_adv       = run_adv & (i_ex_branch_taken | ~load_use);
      flush_ex        = run_adv & (i_ex_branch_taken | load_use);
      enter_wait      = run_adv & ex_q.valid & ex_q.mem_access & (MEM_LATENCY > 1);
      o_pc_enable     = front_adv;
      o_if_id_enable  = front_adv;
      o_id_ex_enable  = run_adv;
      o_ex_mem_enable = run_adv;
      o_flush_if_id   = run_adv & i_ex_branch_taken;
      o_flush_id_ex   = flush_ex;
      o_fwd_rs_sel    = i_reset ? '0 : fwd(ex_q, mem_q, wb_q, i_id_rs_addr, i_id_rs_used);
      o_fwd_rt_sel    = i_reset ? '0 : fwd(ex_q, mem_q, wb_q, i_id_rt_addr, i_id_rt_used);
      o_busy          = ~i_reset & (state_q != RUN);
      state_d         = eff_state;
      cnt_d           = cnt_q;
      if (!i_enable) begin
         state_d = HALT;
      end else if (eff_state == MEM_WAIT && adv) begin
         cnt_d   = cnt_q - NB_CNT'(1);
         state_d = (cnt_q == NB_CNT'(1)) ? RUN : MEM_WAIT;
      end else if (enter_wait) begin
         cnt_d   = NB_CNT'(MEM_LATENCY - 1);
         state_d = MEM_WAIT;
      end
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (run_adv) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = flush_ex ? '0 : {1'b1, i_id_dst_addr, i_id_rf_wr_enb, i_id_is_load, i_id_mem_access};
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: vector table and hand sequences checked through an expected-value queue.
module tb_pipeline_hazard_unit;
   typedef struct {
      string       name;
      logic [3:0]  c;
      logic [4:0]  rs, rt, dst;
      logic [4:0]  f;
      logic        br;
      logic [10:0] e;
   } vec_t;
   typedef struct {
      string       name;
      logic [10:0] e;
      logic        u3;
   } exp_t;

   // c = {reset, enable, step_mode, step}; f = {rs_used, rt_used, wr_enb, is_load, mem_access}
   // e = {pc, if_id, id_ex, ex_mem, flush_if_id, flush_id_ex, rs_sel, rt_sel, busy}
   localparam logic [3:0] RS = 4'b1100, R = 4'b0100, OFF = 4'b0000, SM = 4'b0110, SMP = 4'b0111;

   logic clk = 1'b0;
   logic rst, en, stm, st, rsu, rtu, wr, ld, mem, br;
   logic [4:0] rs, rt, dst;
   logic pc1, ifid1, idex1, exmem1, fif1, fidex1, busy1;
   logic pc3, ifid3, idex3, exmem3, fif3, fidex3, busy3;
   logic [1:0] rss1, rts1, rss3, rts3;
   logic [10:0] a1, a3;
   vec_t tbl[$];
   exp_t sb[$];
   int n_cmp = 0, n_fail = 0, pc_cnt = 0;
   logic count_pc = 1'b0;

   always #5 clk = ~clk;

   assign a1 = {pc1, ifid1, idex1, exmem1, fif1, fidex1, rss1, rts1, busy1};
   assign a3 = {pc3, ifid3, idex3, exmem3, fif3, fidex3, rss3, rts3, busy3};

   pipeline_hazard_unit #(.NB_ADDR(5), .MEM_LATENCY(1), .NB_FWD_SEL(2)) u1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_step_mode(stm), .i_step(st),
      .i_id_rs_addr(rs), .i_id_rt_addr(rt), .i_id_rs_used(rsu), .i_id_rt_used(rtu),
      .i_id_dst_addr(dst), .i_id_rf_wr_enb(wr), .i_id_is_load(ld), .i_id_mem_access(mem),
      .i_ex_branch_taken(br), .o_pc_enable(pc1), .o_if_id_enable(ifid1), .o_id_ex_enable(idex1),
      .o_ex_mem_enable(exmem1), .o_flush_if_id(fif1), .o_flush_id_ex(fidex1),
      .o_fwd_rs_sel(rss1), .o_fwd_rt_sel(rts1), .o_busy(busy1));

   pipeline_hazard_unit #(.NB_ADDR(5), .MEM_LATENCY(3), .NB_FWD_SEL(2)) u3 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_step_mode(stm), .i_step(st),
      .i_id_rs_addr(rs), .i_id_rt_addr(rt), .i_id_rs_used(rsu), .i_id_rt_used(rtu),
      .i_id_dst_addr(dst), .i_id_rf_wr_enb(wr), .i_id_is_load(ld), .i_id_mem_access(mem),
      .i_ex_branch_taken(br), .o_pc_enable(pc3), .o_if_id_enable(ifid3), .o_id_ex_enable(idex3),
      .o_ex_mem_enable(exmem3), .o_flush_if_id(fif3), .o_flush_id_ex(fidex3),
      .o_fwd_rs_sel(rss3), .o_fwd_rt_sel(rts3), .o_busy(busy3));

   function automatic vec_t v(string n, logic [3:0] c, logic [4:0] rs_a, logic [4:0] rt_a,
                              logic [4:0] dst_a, logic [4:0] f, logic b, logic [10:0] e);
      vec_t r;
      r.name = n;
      r.c    = c;
      r.rs   = rs_a;
      r.rt   = rt_a;
      r.dst  = dst_a;
      r.f    = f;
      r.br   = b;
      r.e    = e;
      return r;
   endfunction

   task automatic apply(input vec_t x, input logic use3);
      exp_t q;
      logic [10:0] act;
      @(posedge clk);
      #1;
      {rst, en, stm, st} = x.c;
      rs = x.rs;
      rt = x.rt;
      dst = x.dst;
      {rsu, rtu, wr, ld, mem} = x.f;
      br = x.br;
      sb.push_back('{x.name, x.e, use3});
      @(negedge clk);
      q = sb.pop_front();
      act = q.u3 ? a3 : a1;
      n_cmp++;
      if (act !== q.e) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (pc,ifid,idex,exmem,fif,fidex,rs,rt,busy)", q.name, act, q.e);
      end
      if (count_pc && act[10]) pc_cnt++;
   endtask

   initial begin
      {rst, en, stm, st, rsu, rtu, wr, ld, mem, br} = 10'b1100000000;
      rs = '0;
      rt = '0;
      dst = '0;
      repeat (2) @(posedge clk);
      tbl.push_back(v("reset",        RS, 3, 3, 3, 5'b11100, 0, 11'b0000_00_00_00_0));
      tbl.push_back(v("add3",         R,  1, 2, 3, 5'b11100, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("ex_fwd",       R,  3, 5, 4, 5'b11100, 0, 11'b1111_00_01_00_0));
      tbl.push_back(v("add6",         R,  1, 2, 6, 5'b11100, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("nop1",         R,  0, 0, 0, 5'b00000, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("mem_wb_fwd",   R,  6, 4, 7, 5'b11100, 0, 11'b1111_00_10_11_0));
      tbl.push_back(v("nop2",         R,  0, 0, 0, 5'b00000, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("nop3",         R,  0, 0, 0, 5'b00000, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("wb_fwd",       R,  7, 7, 8, 5'b11100, 0, 11'b1111_00_11_11_0));
      tbl.push_back(v("ex_fwd2",      R,  8, 9, 8, 5'b11100, 0, 11'b1111_00_01_00_0));
      tbl.push_back(v("ex_over_mem",  R,  8, 8, 1, 5'b11100, 0, 11'b1111_00_01_01_0));
      tbl.push_back(v("unused_ops",   R,  1, 8, 0, 5'b00000, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("lw3",          R,  1, 3, 3, 5'b10111, 0, 11'b1111_00_10_00_0));
      tbl.push_back(v("load_use",     R,  3, 3, 4, 5'b11100, 0, 11'b0011_01_00_00_0));
      tbl.push_back(v("after_bubble", R,  3, 3, 4, 5'b11100, 0, 11'b1111_00_10_10_0));
      tbl.push_back(v("lw5",          R,  2, 0, 5, 5'b10111, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("br_over_lu",   R,  5, 0, 6, 5'b11100, 1, 11'b1111_11_00_00_0));
      tbl.push_back(v("flushed_gone", R,  6, 5, 7, 5'b11100, 0, 11'b1111_00_00_10_0));
      tbl.push_back(v("wr_r0",        R,  1, 2, 0, 5'b11100, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("rd_r0",        R,  0, 0, 9, 5'b11100, 0, 11'b1111_00_00_00_0));
      tbl.push_back(v("en_off",       OFF, 9, 0, 0, 5'b10000, 0, 11'b0000_00_01_00_0));
      tbl.push_back(v("halted",       OFF, 9, 0, 0, 5'b10000, 0, 11'b0000_00_01_00_1));
      tbl.push_back(v("resume",       R,  9, 0, 0, 5'b10000, 0, 11'b1111_00_01_00_1));
      tbl.push_back(v("run_again",    R,  9, 0, 0, 5'b10000, 0, 11'b1111_00_10_00_0));
      tbl.push_back(v("step_idle_br", SM, 9, 0, 0, 5'b10000, 1, 11'b0000_00_11_00_0));
      foreach (tbl[i]) apply(tbl[i], 1'b0);
      count_pc = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic p;
         p = (i == 1) || (i == 4) || (i == 8);
         apply(v("step", p ? SMP : SM, 0, 0, 0, 5'b00000, 0, p ? 11'b1111_00_00_00_0 : 11'b0000_00_00_00_0), 1'b0);
      end
      count_pc = 1'b0;
      n_cmp++;
      if (pc_cnt != 3) begin
         n_fail++;
         $display("FAIL step_pc_count: got %0d want 3", pc_cnt);
      end
      apply(v("m_reset",      RS, 0, 0, 0, 5'b00000, 0, 11'b0000_00_00_00_0), 1'b1);
      apply(v("m_sw",         R,  2, 5, 0, 5'b11001, 0, 11'b1111_00_00_00_0), 1'b1);
      apply(v("m_add3",       R,  1, 2, 3, 5'b11100, 0, 11'b1111_00_00_00_0), 1'b1);
      apply(v("m_wait1",      R,  1, 2, 3, 5'b11100, 0, 11'b0000_00_00_00_1), 1'b1);
      for (int i = 0; i < 4; i++)
         apply(v("m_halt_wait", OFF, 1, 2, 3, 5'b11100, 0, 11'b0000_00_00_00_1), 1'b1);
      apply(v("m_wait2",      R,  1, 2, 3, 5'b11100, 0, 11'b0000_00_00_00_1), 1'b1);
      apply(v("m_wait_done",  R,  3, 0, 4, 5'b10100, 0, 11'b1111_00_01_00_0), 1'b1);
      apply(v("m_sw2",        R,  4, 6, 0, 5'b11001, 0, 11'b1111_00_01_00_0), 1'b1);
      apply(v("m_enter_wait", R,  0, 0, 0, 5'b00000, 0, 11'b1111_00_00_00_0), 1'b1);
      apply(v("m_wait_a",     R,  4, 0, 0, 5'b10000, 0, 11'b0000_00_11_00_1), 1'b1);
      apply(v("m_wait_b",     R,  4, 0, 0, 5'b10000, 0, 11'b0000_00_11_00_1), 1'b1);
      apply(v("m_wait_exit",  R,  4, 0, 9, 5'b10100, 0, 11'b1111_00_11_00_0), 1'b1);
      apply(v("m_sw3",        R,  9, 0, 0, 5'b10001, 0, 11'b1111_00_01_00_0), 1'b1);
      apply(v("m_enter3",     R,  9, 0, 0, 5'b10000, 0, 11'b1111_00_10_00_0), 1'b1);
      apply(v("m_wait3",      R,  9, 0, 0, 5'b10000, 0, 11'b0000_00_11_00_1), 1'b1);
      apply(v("m_rst_wait",   RS, 9, 0, 0, 5'b10000, 0, 11'b0000_00_00_00_0), 1'b1);
      apply(v("m_post_rst",   R,  9, 0, 0, 5'b10000, 0, 11'b1111_00_00_00_0), 1'b1);
      apply(v("m_off",        OFF, 0, 0, 0, 5'b00000, 0, 11'b0000_00_00_00_0), 1'b1);
      apply(v("m_cnt_clear",  R,  0, 0, 0, 5'b00000, 0, 11'b1111_00_00_00_1), 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
